// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, FSM encoding and helpers for the AES-128
//               key schedule and round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    // Key-schedule FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    // Round constants indexed by round number; round 0 has no constant
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for any 4-bit index; out-of-range rounds give zero
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx <= 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (8-bit lookup). Shared by the
//               key schedule (SubWord) and the round datapath (SubBytes).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Byte 0x00 occupies the most significant 8 bits, one row of 16 per line
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] top_bit;

    // Locate the entry's most significant bit and slice the byte downward
    always_comb begin
        top_bit  = 11'd2047 - {in_byte, 3'b000};
        out_byte = SBOX[top_bit -: 8];
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key schedule. A load pulse expands the
//               cipher key into 11 round keys, one per clock, held in a
//               buffer with a zero-latency indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand #(
    parameter int NR    = aes_pkg::NR,
    parameter int KEY_W = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [3:0]       rd_idx_i,
    output logic [KEY_W-1:0] rk_o,
    output logic [7:0]       rcon_o,
    output logic             busy_o,
    output logic             ready_o
);
    import aes_pkg::*;

    // Only the AES-128 schedule is implemented
    if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_key_expand supports only NR=10 and KEY_W=128");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [3:0]       idx;
    logic [7:0]       rcon;
    logic             busy;
    logic             ready;
    logic             start;
    logic [KEY_W-1:0] rk [0:NR];
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [31:0]      rot_word;
    logic [31:0]      sub_word;
    logic [31:0]      t_word;
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic [31:0]      w2;
    logic [31:0]      w3;

    // A load is accepted only when no expansion is in flight
    assign start = load_i && ((state == IDLE) || (state == READY));

    // Select rk[idx-1] as the source for the key being generated
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NR; i++) begin
            if (idx == 4'(i + 1)) begin
                prev_key = rk[i];
            end
        end
    end

    assign w0       = prev_key[127:96];
    assign w1       = prev_key[95:64];
    assign w2       = prev_key[63:32];
    assign w3       = prev_key[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    // One round of the word recurrence; each word chains from the previous
    always_comb begin
        t_word   = sub_word ^ {rcon, 24'h0};
        next_key = '0;
        next_key[127:96] = w0 ^ t_word;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    // FSM next-state: loads ignored while expanding
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (idx == 4'(NR)) state_nxt = READY;
            READY:   if (start) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    // State, index, round constant and state-decoded status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 4'd0;
            rcon  <= 8'h01;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == EXPAND);
            ready <= (state_nxt == READY);
            if (start) begin
                idx  <= 4'd1;
                rcon <= 8'h01;
            end else if (state == EXPAND) begin
                idx  <= idx + 4'd1;
                rcon <= xtime(rcon);
            end
        end
    end

    // Round-key buffer: rk[0] on load, rk[idx] on each expansion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else if (start) begin
            rk[0] <= key_i;
        end else if (state == EXPAND) begin
            for (int i = 1; i <= NR; i++) begin
                if (idx == 4'(i)) begin
                    rk[i] <= next_key;
                end
            end
        end
    end

    // Zero-latency read port; indices beyond the last round read as zero
    always_comb begin
        rk_o = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rd_idx_i == 4'(i)) begin
                rk_o = rk[i];
            end
        end
    end

    assign rcon_o  = rcon_lookup(rd_idx_i);
    assign busy_o  = busy;
    assign ready_o = ready;

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key-schedule stage that sits directly upstream of the AES round datapath. On a load, it expands the 128-bit cipher key into 11 round keys, producing one key per clock. It holds all 11 keys in an internal buffer. The round datapath reads any round key by index with zero latency, in forward order for encryption and reverse order for decryption.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is a synthesis error.
KEY_W, 128, key and round-key width in bits; fixed at 128.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
load_i  input  1  one-cycle pulse that starts expansion of key_i
key_i  input  128  cipher key; sampled only on the load_i edge; w0 = key_i[127:96]
rd_idx_i  input  4  round-key index for the read port (0..10)
rk_o  output  128  round key rk[rd_idx_i]; combinational read of the key buffer
rcon_o  output  8  round constant of round rd_idx_i (rd_idx_i = 0 gives 8'h00)
busy_o  output  1  high while expansion is in progress
ready_o  output  1  high when all 11 round keys are valid

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE; rk[0..10] = 0; rcon register = 8'h01; index counter = 0.
  - busy_o = 0; ready_o = 0; rk_o = 0 for all rd_idx_i.
- The FSM has three states: IDLE, EXPAND and READY.
- IDLE:
  - load_i = 1 at an edge: rk[0] <= key_i, idx <= 1, rcon <= 8'h01, go to EXPAND.
- EXPAND: each edge writes rk[idx] computed from rk[idx-1] = {w0, w1, w2, w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - rcon <= xtime(rcon) = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00)
  - idx <= idx + 1
  - On the edge that writes rk[10], go to READY.
- Latency:
  - load_i is sampled at edge T; rk[1..10] are written at edges T+1..T+10.
  - busy_o = 1 from after T until after T+10; ready_o = 1 from after T+10.
  - Exactly 10 busy cycles.
- busy_o and ready_o are registered, state-decoded, and never high together.
- READY:
  - Keys are held indefinitely.
  - load_i = 1 re-enters EXPAND exactly as from IDLE; ready_o drops the cycle after the load edge.
- load_i during EXPAND is ignored: no restart and no error. The upstream controller must wait for busy_o = 0.
- Read port:
  - rk_o = rk[rd_idx_i] for rd_idx_i <= 10, and 128'h0 for 11..15.
  - Reads are legal in any state, but the contents are only guaranteed when ready_o = 1. During EXPAND, indices not yet written return stale or zero data.
- rcon_o table:
  - indices 1..10 give 01 02 04 08 10 20 40 80 1b 36 (combinational ROM);
  - index 0 and 11..15 give 8'h00.
- Reset mid-EXPAND aborts immediately: all keys are cleared and the FSM returns to IDLE. A subsequent load_i behaves normally.
- Only rk[0..10] are stored as 128-bit registers; there is no key write-back or masking.

Decomposition:
- Package aes_pkg holds:
  - the state encoding (IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2);
  - NR and KEY_W;
  - the RCON constant table;
  - an xtime function.
- Sub-module aes_sbox: a combinational 8-bit S-box lookup. Four instances implement SubWord. The round datapath reuses the same module.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, pulse load_i -> busy_o high for exactly 10 cycles, then ready_o = 1; rk_o at idx 0/1/10 = key / a0fafe1788542cb123a339392a6c7605 / d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 128'h0 -> rk[1] = 62636363626363636263636362636363 and rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e; rcon_o at idx 1..10 matches the table and idx 0 gives 00.
- Pulse load_i with a second key 3 cycles into EXPAND -> ignored; the final keys match the first key and ready_o arrives at the original T+10.
- Assert rst at cycle 5 of EXPAND -> busy_o and ready_o are 0 immediately and rk_o = 0 for all idx; a new load completes in 10 cycles with correct keys.
- From READY, load a new key -> ready_o drops the next cycle; rk[10] updates to the new key's value after 10 cycles.
- Sweep rd_idx_i 11..15 in READY -> rk_o = 0 and rcon_o = 00.
